// File: rtl/timing_pkg.sv
// timing_pkg
// Shared types and constants for round-timing blocks.
//   timer_state_t : countdown controller state
//   clog2()       : counter width for a divide ratio (never below 1 bit)
//   CLK_FREQ_HZ_DEFAULT / ROUND_TIME_DEFAULT : board clock and default round length
package timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } timer_state_t;

    localparam int CLK_FREQ_HZ_DEFAULT = 100000000;
    localparam int ROUND_TIME_DEFAULT  = 100;

    function automatic int clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/game_countdown_timer_if.sv
// game_countdown_timer_if
// Control/status bundle between the game-control FSM (master) and the
// countdown timer (slave).
//   start, pause, load, add_time : single-cycle control pulses
//   load_value, add_value        : operands for load / add_time
//   count                        : remaining ticks
//   running, done, warning       : registered status levels
//   expired                      : one-cycle pulse when count reaches zero
interface game_countdown_timer_if #(
    parameter int COUNT_WIDTH = 16
) ();
    logic                   start;
    logic                   pause;
    logic                   load;
    logic [COUNT_WIDTH-1:0] load_value;
    logic                   add_time;
    logic [COUNT_WIDTH-1:0] add_value;
    logic [COUNT_WIDTH-1:0] count;
    logic                   running;
    logic                   done;
    logic                   expired;
    logic                   warning;

    modport master (
        output start, pause, load, load_value, add_time, add_value,
        input  count, running, done, expired, warning
    );

    modport slave (
        input  start, pause, load, load_value, add_time, add_value,
        output count, running, done, expired, warning
    );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Free-running 0..DIV-1 counter that advances only while enabled and holds
// its value otherwise, so a paused consumer resumes mid-period.
//   clock_100Mhz : clock
//   reset        : synchronous, active-high
//   enable       : advance the counter this cycle
//   clear        : force the counter to zero (wins over enable)
//   tick         : high on the enabled cycle where the counter sits at DIV-1
module tick_prescaler
    import timing_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clock_100Mhz,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int            CW   = clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock_100Mhz) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = enable && (cnt_q == LAST);
endmodule

// File: rtl/game_countdown_timer.sv
// game_countdown_timer
// Round countdown for the crane game. Decrements count once per tick period
// while RUNNING, raises warning near the end and pulses expired on reaching
// zero (optionally reloading and continuing).
//   clock_100Mhz : clock
//   reset        : synchronous, active-high
//   bus          : slave side of game_countdown_timer_if (controls in, status out)
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | stopped, prescaler cleared, waiting for start
// RUNNING | prescaler advancing, count decremented on each tick
// PAUSED  | frozen, prescaler holds its phase
// DONE    | reached zero, count held at 0 until start
module game_countdown_timer
    import timing_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = CLK_FREQ_HZ_DEFAULT,
    parameter int TICK_HZ        = 1,
    parameter int COUNT_WIDTH    = 16,
    parameter int START_TIME     = ROUND_TIME_DEFAULT,
    parameter int WARN_THRESHOLD = 10,
    parameter bit AUTO_RELOAD    = 1'b0
) (
    input  logic clock_100Mhz,
    input  logic reset,
    game_countdown_timer_if.slave bus
);
    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

    if (TICK_HZ < 1 || DIV < 2 || (CLK_FREQ_HZ % TICK_HZ) != 0) begin : g_bad_div
        $error("game_countdown_timer: CLK_FREQ_HZ/TICK_HZ must be an exact ratio >= 2");
    end
    if (START_TIME < 0 || longint'(START_TIME) >= (longint'(1) << COUNT_WIDTH)) begin : g_bad_start
        $error("game_countdown_timer: START_TIME does not fit in COUNT_WIDTH");
    end

    localparam logic [COUNT_WIDTH-1:0] START_VAL = COUNT_WIDTH'(START_TIME);
    localparam logic [COUNT_WIDTH:0]   COUNT_MAX = {1'b0, {COUNT_WIDTH{1'b1}}};
    // Thresholds beyond the count range simply mean "always warn when nonzero".
    localparam logic [COUNT_WIDTH:0]   WARN_LIM  =
        (longint'(WARN_THRESHOLD) >= (longint'(1) << COUNT_WIDTH)) ? COUNT_MAX
                                                                  : (COUNT_WIDTH+1)'(WARN_THRESHOLD);
    localparam logic WARN_AT_START = (START_VAL != '0) && ({1'b0, START_VAL} <= WARN_LIM);

    timer_state_t           state_q, state_next;
    logic [COUNT_WIDTH-1:0] count_q, count_next, count_sat;
    logic [COUNT_WIDTH:0]   add_ext, sum_ext;
    logic                   expired_q, expired_next;
    logic                   running_q, done_q, warning_q, warning_next;
    logic                   tick, dec, pre_clear;

    // Prescaler is parked at zero outside RUNNING/PAUSED, so any start from
    // IDLE or DONE begins a full period; a load also restarts the phase.
    assign pre_clear = bus.load || (state_q == ST_IDLE) || (state_q == ST_DONE);

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .enable       (state_q == ST_RUNNING),
        .clear        (pre_clear),
        .tick         (tick)
    );

    // Bonus time and the tick decrement are folded into one saturating sum,
    // so a bonus landing on the final tick keeps the round alive.
    always_comb begin
        dec       = tick && (state_q == ST_RUNNING) && (count_q != '0);
        add_ext   = (bus.add_time && (state_q != ST_DONE)) ? {1'b0, bus.add_value} : '0;
        sum_ext   = {1'b0, count_q} + add_ext - {{COUNT_WIDTH{1'b0}}, dec};
        count_sat = (sum_ext > COUNT_MAX) ? COUNT_MAX[COUNT_WIDTH-1:0] : sum_ext[COUNT_WIDTH-1:0];
    end

    always_comb begin
        state_next   = state_q;
        count_next   = count_q;
        expired_next = 1'b0;
        if (bus.load) begin
            count_next = bus.load_value;
            state_next = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_next = count_sat;
                    if (bus.start) begin
                        if (count_sat == '0) begin
                            state_next   = ST_DONE;
                            expired_next = 1'b1;
                        end else begin
                            state_next = ST_RUNNING;
                        end
                    end
                end
                ST_RUNNING: begin
                    count_next = count_sat;
                    if (bus.pause) begin
                        state_next = ST_PAUSED;
                    end
                    if (dec && (count_sat == '0)) begin
                        expired_next = 1'b1;
                        if (AUTO_RELOAD) begin
                            count_next = START_VAL;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_PAUSED: begin
                    count_next = count_sat;
                    if (bus.start) begin
                        state_next = ST_RUNNING;
                    end
                end
                ST_DONE: begin
                    count_next = '0;
                    if (bus.start) begin
                        count_next = START_VAL;
                        state_next = ST_RUNNING;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
        warning_next = (count_next != '0) && ({1'b0, count_next} <= WARN_LIM);
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= START_VAL;
            expired_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            warning_q <= WARN_AT_START;
        end else begin
            state_q   <= state_next;
            count_q   <= count_next;
            expired_q <= expired_next;
            running_q <= (state_next == ST_RUNNING);
            done_q    <= (state_next == ST_DONE);
            warning_q <= warning_next;
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.expired = expired_q;
    assign bus.warning = warning_q;
endmodule

// File: doc/game_countdown_timer.md
Name: game_countdown_timer

Overview:
- Parametrised countdown timer for crane-game round timing. Generalises the fixed 1 Hz, start-100 countdown.
- Adds: configurable clock and tick rate, count width, start value and warning threshold; start/pause/load/add-time controls; expiry pulse; optional auto-reload mode.
- Sits between the game-control FSM (drives controls, consumes expired/warning) and the display path (consumes count).

Parameters:
- CLK_FREQ_HZ, 100000000, input clock frequency.
- TICK_HZ, 1, decrement rate; DIV = CLK_FREQ_HZ/TICK_HZ. DIV must be ≥2 and exact (elaboration-time check).
- COUNT_WIDTH, 16, width of count, load_value and add_value.
- START_TIME, 100, value after reset and on restart from DONE; must be < 2^COUNT_WIDTH.
- WARN_THRESHOLD, 10, warning is asserted when 0 < count ≤ WARN_THRESHOLD.
- AUTO_RELOAD, 0, when 1, reaching zero reloads START_TIME and keeps running.

Ports:
- clock_100Mhz  in  1  system clock.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock_100Mhz only.
- start  in  1  single-cycle pulse: begin or resume counting.
- pause  in  1  single-cycle pulse: freeze counting.
- load  in  1  single-cycle pulse: count <= load_value; go to IDLE.
- load_value  in  COUNT_WIDTH  value used by load.
- add_time  in  1  single-cycle pulse: add add_value (bonus time).
- add_value  in  COUNT_WIDTH  bonus amount.
- count  out  COUNT_WIDTH  current remaining ticks.
- running  out  1  high in RUNNING.
- done  out  1  high in DONE.
- expired  out  1  one-cycle pulse on the cycle count becomes 0 from a tick.
- warning  out  1  registered; high when 0 < count ≤ WARN_THRESHOLD.

Behaviour:
- Reset values: state=IDLE, count=START_TIME, prescaler=0, running=0, done=0, expired=0. warning reflects START_TIME against the threshold on the cycle after reset.
- States: IDLE, RUNNING, PAUSED, DONE. Encoding is one-hot or binary (implementer's choice).
- Prescaler:
  - Counts 0..DIV-1 only in RUNNING; holds in PAUSED.
  - Cleared in IDLE and DONE, and on start, load and reset.
  - tick = RUNNING && prescaler==DIV-1. The first tick after start occurs exactly DIV cycles after the start edge.
- Priority, highest first: reset > load > start/pause > add_time/tick.
- IDLE:
  - start with count>0 -> RUNNING.
  - start with count==0 -> DONE next cycle; expired pulses once.
- RUNNING:
  - tick decrements count.
  - tick taking count 1->0:
    - AUTO_RELOAD=0: -> DONE, expired=1 for one cycle.
    - AUTO_RELOAD=1: count <= START_TIME, stay RUNNING, expired=1 for one cycle.
  - pause -> PAUSED. A tick in the same cycle is still applied.
  - start is ignored.
- PAUSED: start -> RUNNING and the prescaler resumes from its held value. pause is ignored.
- DONE: count holds 0. start reloads START_TIME and goes to RUNNING. pause is ignored.
- load (any state): count <= load_value, state -> IDLE, expired=0. Any tick in that cycle is discarded.
- add_time:
  - Accepted in IDLE, RUNNING and PAUSED; ignored in DONE.
  - count <= min(count + add_value − tick, 2^COUNT_WIDTH−1). Use a COUNT_WIDTH+1 intermediate; no wrap-around.
  - A simultaneous tick on count==1 with add_value≥1 does not expire.
- count never underflows.
- running, done and warning are registered outputs with no combinational input-to-output paths.

Decomposition:
- Shared package timing_pkg:
  - state enum (IDLE/RUNNING/PAUSED/DONE).
  - function clog2 for prescaler width: $clog2(DIV).
  - default constants CLK_FREQ_HZ_DEFAULT=100000000 and ROUND_TIME_DEFAULT=100.
- One sub-module, tick_prescaler:
  - Parameter DIV; inputs clock_100Mhz, reset, enable, clear; output tick.
  - Reusable for display-refresh and LED blink rates.

Test Plan (CLK_FREQ_HZ=10, TICK_HZ=1 -> DIV=10, COUNT_WIDTH=8, START_TIME=5, WARN_THRESHOLD=2):
- Reset then start at cycle 0 -> count 5,4,3,2,1,0 at cycles 10,20,30,40,50. warning rises with count=2; done=1 and a single-cycle expired pulse at count 0. count stays 0 for 100 more cycles.
- Start, pause at cycle 14, start at cycle 40 -> count stays 4 during the pause; next decrement at cycle 46 (prescaler resumed at 4).
- add_time with add_value=3 coincident with the tick taking count 1->0 -> count=3, no expired, state stays RUNNING. Then add_value=255 -> count saturates at 255.
- load_value=0 then start -> done=1 next cycle and expired pulses once. Start again from DONE -> count=5, running=1.
- AUTO_RELOAD=1 -> count 1->0 tick gives count=5, expired pulse, running stays 1; pulse period is 50 cycles.
- reset asserted mid-count at count=3 -> next edge count=5, IDLE, expired=0. reset held over a tick boundary produces no decrement.
